// File: rtl/key_input.sv
// Push-button byte entry: synchronizes and debounces a button, then shifts the
// switch byte into a 32-bit word on each press and holds the word until acknowledged.
module key_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic [7:0]  sw_raw,
  input  logic        data_ack,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [31:0] preview,
  output logic [2:0]  byte_count,
  output logic        overrun
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  logic        btn_meta;
  logic        btn_s;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_s;
  logic        db;
  logic [15:0] cnt;
  logic        press;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] data_out_nxt;
  logic [31:0] preview_nxt;
  logic [2:0]  byte_count_nxt;
  logic        overrun_nxt;

  function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [7:0] b);
    return {acc[23:0], b};
  endfunction

  // Stage: two-flop synchronizers for the asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
      sw_meta  <= sw_raw;
      sw_s     <= sw_meta;
    end
  end

  // Stage: debounce -- the level must disagree for DEBOUNCE_CYCLES straight edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (btn_s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      db  <= btn_s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Acted on at the very edge where db rises; releases produce nothing.
  assign press = btn_s & ~db & (cnt == CNT_MAX);

  // Stage: word assembly FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      data_out   <= '0;
      preview    <= '0;
      byte_count <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_out   <= data_out_nxt;
      preview    <= preview_nxt;
      byte_count <= byte_count_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    data_out_nxt   = data_out;
    preview_nxt    = preview;
    byte_count_nxt = byte_count;
    overrun_nxt    = overrun;
    case (state)
      COLLECT: begin
        if (press) begin
          if (byte_count == 3'd3) begin
            data_out_nxt   = shift_in(preview, sw_s);
            preview_nxt    = '0;
            byte_count_nxt = '0;
            state_nxt      = HOLD;
          end else begin
            preview_nxt    = shift_in(preview, sw_s);
            byte_count_nxt = byte_count + 3'd1;
          end
        end
      end
      HOLD: begin
        // An acknowledge wins over a coincident press, which is silently dropped.
        if (data_ack) begin
          overrun_nxt = 1'b0;
          state_nxt   = COLLECT;
        end else if (press) begin
          overrun_nxt = 1'b1;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign data_valid = (state == HOLD);

endmodule

// File: tb/tb_key_input.sv
// Bench for key_input: directed vector table, hand sequences for latency, bounce
// and async reset, then random stimulus against a run-length/queue reference model.
module tb_key_input;

  localparam int DEB = 4;

  logic        clk;
  logic        rst;
  logic        btn_raw;
  logic [7:0]  sw_raw;
  logic        data_ack;
  logic [31:0] data_out;
  logic        data_valid;
  logic [31:0] preview;
  logic [2:0]  byte_count;
  logic        overrun;

  key_input #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .data_ack(data_ack),
    .data_out(data_out), .data_valid(data_valid), .preview(preview),
    .byte_count(byte_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check_out(input string name, input logic [31:0] pv, input logic [2:0] bc,
                           input logic dv, input logic [31:0] dout, input logic ov);
    vectors++;
    if (preview !== pv || byte_count !== bc || data_valid !== dv ||
        data_out !== dout || overrun !== ov) begin
      errors++;
      $display("FAIL %s @%0t: got pv=%h bc=%0d dv=%b dout=%h ov=%b, want pv=%h bc=%0d dv=%b dout=%h ov=%b",
               name, $time, preview, byte_count, data_valid, data_out, overrun,
               pv, bc, dv, dout, ov);
    end
  endtask

  // Reference model: button history queue, run-length debounce, byte queue.
  logic       q_btn[$];
  logic [7:0] q_sw[$];
  logic       m_db;
  int         m_run;
  logic [7:0] m_bytes[$];
  logic       m_hold;
  logic [31:0] m_word;
  logic       m_ovr;

  function automatic logic [31:0] m_preview();
    logic [31:0] pv = '0;
    foreach (m_bytes[i]) pv = {pv[23:0], m_bytes[i]};
    return pv;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic s;
    logic [7:0] sws;
    logic prs;
    if (rst) begin
      q_btn.delete(); q_sw.delete(); m_bytes.delete();
      m_db = 1'b0; m_run = 0; m_hold = 1'b0; m_word = '0; m_ovr = 1'b0;
    end else begin
      q_btn.push_back(btn_raw);
      q_sw.push_back(sw_raw);
      if (q_btn.size() > 3) begin
        void'(q_btn.pop_front());
        void'(q_sw.pop_front());
      end
      s   = (q_btn.size() == 3) ? q_btn[0] : 1'b0;
      sws = (q_sw.size() == 3) ? q_sw[0] : 8'h00;
      prs = 1'b0;
      if (s != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db = s; m_run = 0; prs = s;
        end
      end else begin
        m_run = 0;
      end
      if (m_hold) begin
        if (data_ack) begin m_hold = 1'b0; m_ovr = 1'b0; end
        else if (prs) m_ovr = 1'b1;
      end else if (prs) begin
        m_bytes.push_back(sws);
        if (m_bytes.size() == 4) begin
          m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_hold = 1'b1;
          m_bytes.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) check_out("model", m_preview(), 3'(m_bytes.size()), m_hold, m_word, m_ovr);
  end

  typedef struct {
    logic        btn;
    logic [7:0]  sw;
    logic        ack;
    int          cycles;
    logic [31:0] pv;
    logic [2:0]  bc;
    logic        dv;
    logic [31:0] dout;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic btn, input logic [7:0] sw, input logic ack, input int cycles,
                     input logic [31:0] pv, input logic [2:0] bc, input logic dv,
                     input logic [31:0] dout, input logic ov);
    vec_t v;
    v.btn = btn; v.sw = sw; v.ack = ack; v.cycles = cycles;
    v.pv = pv; v.bc = bc; v.dv = dv; v.dout = dout; v.ov = ov;
    tbl.push_back(v);
  endtask

  initial begin
    int hold;
    rst = 1'b1; btn_raw = 1'b0; sw_raw = 8'h00; data_ack = 1'b0;
    #3 check_out("reset_state", '0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First press latency: nothing at edge 5, byte taken at edge 6.
    sw_raw = 8'h12;
    repeat (3) @(negedge clk);
    btn_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_out("latency_edge5", '0, '0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 check_out("latency_edge6", 32'h12, 3'd1, 1'b0, '0, 1'b0);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // btn sw ack cycles | preview bc dv data_out ov
    add(0, 8'h00, 0, 8, 32'h0,        0, 0, 32'h0,        0);
    add(1, 8'hDE, 0, 8, 32'hDE,       1, 0, 32'h0,        0);
    add(0, 8'hDE, 0, 8, 32'hDE,       1, 0, 32'h0,        0);
    add(1, 8'hAD, 0, 8, 32'hDEAD,     2, 0, 32'h0,        0);
    add(0, 8'hAD, 0, 8, 32'hDEAD,     2, 0, 32'h0,        0);
    add(1, 8'hBE, 0, 8, 32'hDEADBE,   3, 0, 32'h0,        0);
    add(0, 8'hBE, 0, 8, 32'hDEADBE,   3, 0, 32'h0,        0);
    add(1, 8'hEF, 0, 8, 32'h0,        0, 1, 32'hDEADBEEF, 0);
    add(0, 8'hEF, 0, 8, 32'h0,        0, 1, 32'hDEADBEEF, 0);
    add(1, 8'h55, 0, 8, 32'h0,        0, 1, 32'hDEADBEEF, 1);
    add(0, 8'h55, 0, 8, 32'h0,        0, 1, 32'hDEADBEEF, 1);
    add(0, 8'h55, 1, 1, 32'h0,        0, 0, 32'hDEADBEEF, 0);
    add(0, 8'h55, 0, 4, 32'h0,        0, 0, 32'hDEADBEEF, 0);
    add(1, 8'h77, 0, 8, 32'h77,       1, 0, 32'hDEADBEEF, 0);
    add(0, 8'h77, 0, 8, 32'h77,       1, 0, 32'hDEADBEEF, 0);
    add(1, 8'h01, 0, 8, 32'h7701,     2, 0, 32'hDEADBEEF, 0);
    add(0, 8'h01, 0, 8, 32'h7701,     2, 0, 32'hDEADBEEF, 0);
    add(1, 8'h02, 0, 8, 32'h770102,   3, 0, 32'hDEADBEEF, 0);
    add(0, 8'h02, 0, 8, 32'h770102,   3, 0, 32'hDEADBEEF, 0);
    add(1, 8'h03, 0, 8, 32'h0,        0, 1, 32'h77010203, 0);
    add(0, 8'h03, 0, 8, 32'h0,        0, 1, 32'h77010203, 0);
    // ack lands on the same edge as the press event (6th edge after btn rises)
    add(1, 8'h99, 0, 5, 32'h0,        0, 1, 32'h77010203, 0);
    add(1, 8'h99, 1, 1, 32'h0,        0, 0, 32'h77010203, 0);
    add(1, 8'h99, 0, 3, 32'h0,        0, 0, 32'h77010203, 0);
    add(0, 8'h99, 0, 8, 32'h0,        0, 0, 32'h77010203, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      btn_raw = tbl[i].btn; sw_raw = tbl[i].sw; data_ack = tbl[i].ack;
      repeat (tbl[i].cycles) @(posedge clk);
      #1 check_out($sformatf("table_%0d", i), tbl[i].pv, tbl[i].bc, tbl[i].dv,
                   tbl[i].dout, tbl[i].ov);
    end
    data_ack = 1'b0;

    // Bounce shorter than the debounce window must be ignored.
    @(negedge clk);
    sw_raw = 8'h5A; btn_raw = 1'b1;
    repeat (8) @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    check_out("pre_bounce", 32'h5A, 3'd1, 1'b0, 32'h77010203, 1'b0);
    sw_raw = 8'hC3;
    for (int t = 0; t < 10; t++) begin
      btn_raw = ~btn_raw;
      repeat (2) @(negedge clk);
    end
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
    check_out("post_bounce", 32'h5A, 3'd1, 1'b0, 32'h77010203, 1'b0);

    // Async reset mid-word, with the button held through reset.
    sw_raw = 8'h6B; btn_raw = 1'b1;
    repeat (8) @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    check_out("two_bytes", 32'h5A6B, 3'd2, 1'b0, 32'h77010203, 1'b0);
    btn_raw = 1'b1; sw_raw = 8'h3C;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_out("async_reset", '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_out("post_reset_edge5", '0, '0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 check_out("post_reset_edge6", 32'h3C, 3'd1, 1'b0, '0, 1'b0);
    @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);

    // Random phase, checked every cycle by the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        btn_raw = 1'($urandom);
        sw_raw  = 8'($urandom);
        hold    = $urandom_range(1, 12);
      end
      hold--;
      data_ack = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0; data_ack = 1'b0; btn_raw = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/key_input.md
KEY_INPUT -- requirements
Module: key_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive cycles a synchronized button level must differ from the debounced level before it is accepted (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port btn_raw, input, 1 bit: asynchronous push-button, high = pressed.
REQ-005 The block SHALL have port sw_raw, input, 8 bits: asynchronous switch byte.
REQ-006 The block SHALL have port data_ack, input, 1 bit: consumer (CPU syscall path) accepts data_out.
REQ-007 The block SHALL have port data_out, output, 32 bits: completed word, first-entered byte in [31:24].
REQ-008 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-009 The block SHALL have port preview, output, 32 bits: live accumulator, suitable for driving the LED display.
REQ-010 The block SHALL have port byte_count, output, 3 bits: bytes collected in the current word (0..3).
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set by a press dropped while data_valid=1.

Function
REQ-012 btn_raw and sw_raw SHALL each pass through a two-flop synchronizer (btn_s, sw_s) before any use.
REQ-013 Debounce: register db plus counter cnt; btn_s==db -> cnt<=0; btn_s!=db and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; btn_s!=db and cnt==DEBOUNCE_CYCLES-1 -> db<=btn_s, cnt<=0.
REQ-014 A press event SHALL be the condition (btn_s=1, db=0, cnt==DEBOUNCE_CYCLES-1), acted on at the same edge where db rises; releases generate no event.
REQ-015 Latency: btn_raw rising before edge 1 and held SHALL give db=1, with the press acted on, at rising edge DEBOUNCE_CYCLES+2; any bounce resets cnt and restarts the count.
REQ-016 The FSM SHALL have two states: COLLECT and HOLD.
REQ-017 COLLECT, press, byte_count<3: preview<={preview[23:0],sw_s}; byte_count<=byte_count+1.
REQ-018 COLLECT, press, byte_count==3: data_out<={preview[23:0],sw_s}, data_valid<=1, preview<=0, byte_count<=0, state<=HOLD.
REQ-019 HOLD, press, data_ack=0: press SHALL be dropped, overrun<=1; preview and byte_count unchanged.
REQ-020 HOLD, data_ack=1: data_valid<=0, overrun<=0, state<=COLLECT at that edge; a press on the same edge SHALL be dropped and SHALL NOT set overrun.
REQ-021 data_ack in COLLECT SHALL be ignored.
REQ-022 data_out SHALL hold its value from the edge data_valid rises until the next completed word.
REQ-023 data_valid SHALL be high iff state==HOLD.

Reset
REQ-024 rst=1 SHALL immediately force state=COLLECT, data_out=0, data_valid=0, preview=0, byte_count=0, overrun=0, db=0, cnt=0, and all synchronizer flops=0.
REQ-025 Reset mid-word or mid-debounce SHALL discard partial bytes and count; after release, a button already held SHALL be seen as a fresh press after DEBOUNCE_CYCLES+2 edges.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 sw_raw=0x12, btn_raw 0->1 held -> preview=0x00000012, byte_count=1 at edge 6 after the change, not earlier.
REQ-027 Four clean presses with sw_raw=0xDE,0xAD,0xBE,0xEF -> data_out=0xDEADBEEF, data_valid=1, byte_count=0, preview=0.
REQ-028 btn_raw toggling every 2 cycles for 20 cycles, then low -> no change to preview, byte_count or data_valid.
REQ-029 data_valid=1, fifth press, no ack -> overrun=1, data_out still 0xDEADBEEF; then data_ack=1 for 1 cycle -> data_valid=0, overrun=0.
REQ-030 data_ack pulse and press event on the same edge in HOLD -> data_valid=0, overrun=0, byte_count=0.
REQ-031 rst pulsed after 2 bytes collected -> all outputs 0 immediately, before the next clk edge.
